// File: rtl/fp32_matmul_pkg.sv
// Shared widths, FP32 constants and sequencer state encoding for the FP32 matmul operand
// sequencer.
package fp32_matmul_pkg;

  localparam int unsigned FP32_W  = 32;
  localparam int unsigned VEC_LEN = 16;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_e;

endpackage

// File: rtl/fp32_tag_pipe.sv
// Fixed-depth delay line for a {valid, tag} pair. It advances every cycle, and an
// asynchronous reset invalidates every stage.
module fp32_tag_pipe #(
  parameter int unsigned Depth = 6,
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [Width-1:0] in_tag,
  output logic             out_valid,
  output logic [Width-1:0] out_tag
);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] tag_q [Depth];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < Depth; s++) tag_q[s] <= '0;
    end else begin
      valid_q  <= {valid_q[Depth-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int s = 1; s < Depth; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign out_valid = valid_q[Depth-1];
  assign out_tag   = tag_q[Depth-1];

endmodule

// File: rtl/fp32_matmul_sequencer.sv
// Streams every (row of A, column of B) pair to a pipelined FP32 dot-product unit.
// It then re-attaches the (i,j) tag to each returning result.
module fp32_matmul_sequencer
  import fp32_matmul_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned IW      = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_wr_en,
  input  logic [IW-1:0]             a_wr_row,
  input  logic [3:0]                a_wr_col,
  input  logic [FP32_W-1:0]         a_wr_data,
  input  logic                      b_wr_en,
  input  logic [3:0]                b_wr_row,
  input  logic [IW-1:0]             b_wr_col,
  input  logic [FP32_W-1:0]         b_wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [VEC_LEN*FP32_W-1:0] vec_a,
  output logic [VEC_LEN*FP32_W-1:0] vec_b,
  input  logic [FP32_W-1:0]         mul_result,
  output logic                      c_valid,
  output logic [IW-1:0]             c_row,
  output logic [IW-1:0]             c_col,
  output logic [FP32_W-1:0]         c_data
);

  localparam int unsigned PW = 2 * IW;

  logic [FP32_W-1:0] a_buf_q [N][VEC_LEN];
  logic [FP32_W-1:0] b_buf_q [VEC_LEN][N];
  seq_state_e        state_q;
  logic [PW-1:0]     pair_q;

  logic                      a_wr_ok, b_wr_ok;
  logic                      issue_fire, issue_last;
  logic [PW-1:0]             issue_p;
  logic [IW-1:0]             issue_i, issue_j;
  logic [VEC_LEN*FP32_W-1:0] row_a, col_b;
  logic                      tag_valid, done_d;
  logic [PW-1:0]             tag_p;

  assign a_wr_ok    = a_wr_en && (state_q == IDLE);
  assign b_wr_ok    = b_wr_en && (state_q == IDLE);
  assign issue_fire = ((state_q == IDLE) && start) || (state_q == ISSUE);
  // N is a power of two, so the pair index p = i*N + j is simply {i, j}.
  assign issue_p    = (state_q == IDLE) ? '0 : pair_q;
  assign issue_i    = issue_p[PW-1:IW];
  assign issue_j    = issue_p[IW-1:0];
  assign issue_last = &issue_p;
  assign done_d     = tag_valid && (&tag_p);

  always_comb begin
    for (int k = 0; k < VEC_LEN; k++) begin
      row_a[k*FP32_W +: FP32_W] = a_buf_q[issue_i][k];
      col_b[k*FP32_W +: FP32_W] = b_buf_q[k][issue_j];
    end
    // Forward a write presented together with start so that the first pair sees it.
    if (a_wr_ok && (a_wr_row == issue_i)) row_a[a_wr_col*FP32_W +: FP32_W] = a_wr_data;
    if (b_wr_ok && (b_wr_col == issue_j)) col_b[b_wr_row*FP32_W +: FP32_W] = b_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < VEC_LEN; k++) a_buf_q[r][k] <= FP32_ZERO;
      end
      for (int k = 0; k < VEC_LEN; k++) begin
        for (int c = 0; c < N; c++) b_buf_q[k][c] <= FP32_ZERO;
      end
    end else begin
      if (a_wr_ok) a_buf_q[a_wr_row][a_wr_col] <= a_wr_data;
      if (b_wr_ok) b_buf_q[b_wr_row][b_wr_col] <= b_wr_data;
    end
  end

  fp32_tag_pipe #(
    .Depth(LATENCY + 1),
    .Width(PW)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue_fire),
    .in_tag   (issue_p),
    .out_valid(tag_valid),
    .out_tag  (tag_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pair_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vec_a   <= '0;
      vec_b   <= '0;
      c_valid <= 1'b0;
      c_row   <= '0;
      c_col   <= '0;
      c_data  <= FP32_ZERO;
    end else begin
      done    <= done_d;
      c_valid <= tag_valid;
      if (tag_valid) begin
        c_row  <= tag_p[PW-1:IW];
        c_col  <= tag_p[IW-1:0];
        c_data <= mul_result;
      end
      if (issue_fire) begin
        vec_a  <= row_a;
        vec_b  <= col_b;
        pair_q <= issue_p + 1'b1;
      end
      case (state_q)
        IDLE: begin
          // done only pulses while back in IDLE; busy falls after it unless relaunched.
          if (start) begin
            state_q <= ISSUE;
            busy    <= 1'b1;
          end else if (done) begin
            busy <= 1'b0;
          end
        end
        ISSUE:   if (issue_last) state_q <= DRAIN;
        DRAIN:   if (done_d) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_matmul_sequencer.sv
// Self-checking bench for fp32_matmul_sequencer: it uses table and random matrices, a
// pipelined dot-product model, and corner sequences for write guard, start hazards,
// reset and a small configuration.
module tb_fp32_matmul_sequencer;
  import fp32_matmul_pkg::*;

  localparam int N1   = 4;
  localparam int L1   = 5;
  localparam int IW1  = 2;
  localparam int NN1  = N1 * N1;
  localparam int TOT1 = NN1 + L1 + 1;
  localparam int N2   = 2;
  localparam int L2   = 1;
  localparam int IW2  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start, a_wr_en, b_wr_en, busy, done, c_valid;
  logic [IW1-1:0] a_wr_row, b_wr_col, c_row, c_col;
  logic [3:0]     a_wr_col, b_wr_row;
  logic [31:0]    a_wr_data, b_wr_data, mul_result, c_data;
  logic [511:0]   vec_a, vec_b;

  logic           start2, a2_en, b2_en, busy2, done2, cv2;
  logic [IW2-1:0] a2_row, b2_col, cr2, cc2;
  logic [3:0]     a2_col, b2_row;
  logic [31:0]    a2_data, b2_data, mr2, cd2;
  logic [511:0]   va2, vb2;

  fp32_matmul_sequencer #(.N(N1), .LATENCY(L1)) dut (
    .clk(clk), .rst(rst),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_col(a_wr_col), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_col(b_wr_col), .b_wr_data(b_wr_data),
    .start(start), .busy(busy), .done(done), .vec_a(vec_a), .vec_b(vec_b),
    .mul_result(mul_result), .c_valid(c_valid), .c_row(c_row), .c_col(c_col),
    .c_data(c_data)
  );

  fp32_matmul_sequencer #(.N(N2), .LATENCY(L2)) dut2 (
    .clk(clk), .rst(rst),
    .a_wr_en(a2_en), .a_wr_row(a2_row), .a_wr_col(a2_col), .a_wr_data(a2_data),
    .b_wr_en(b2_en), .b_wr_row(b2_row), .b_wr_col(b2_col), .b_wr_data(b2_data),
    .start(start2), .busy(busy2), .done(done2), .vec_a(va2), .vec_b(vb2),
    .mul_result(mr2), .c_valid(cv2), .c_row(cr2), .c_col(cc2), .c_data(cd2)
  );

  // Multiplier stand-in: integer dot product of the raw bit patterns, modulo 2^32.
  function automatic logic [31:0] dot(input logic [511:0] va, input logic [511:0] vb);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) s += va[k*32 +: 32] * vb[k*32 +: 32];
    return s;
  endfunction

  logic [31:0] mpipe [L1];
  always @(posedge clk) begin
    mpipe[0] <= dot(vec_a, vec_b);
    for (int s = 1; s < L1; s++) mpipe[s] <= mpipe[s-1];
  end
  assign mul_result = mpipe[L1-1];

  logic [31:0] mpipe2;
  always @(posedge clk) mpipe2 <= dot(va2, vb2);
  assign mr2 = mpipe2;

  // Reference matrices: what the DUT buffers should hold.
  logic [31:0] ref_a [N1][16];
  logic [31:0] ref_b [16][N1];

  function automatic logic [511:0] row_of(input int i);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = ref_a[i][k];
    return r;
  endfunction

  function automatic logic [511:0] col_of(input int j);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = ref_b[k][j];
    return r;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load_ref();
    for (int i = 0; i < N1; i++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_row = IW1'(i); a_wr_col = 4'(k); a_wr_data = ref_a[i][k];
        b_wr_en = 1'b1; b_wr_row = 4'(k); b_wr_col = IW1'(i); b_wr_data = ref_b[k][i];
      end
    end
    @(negedge clk);
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  // One full run, checked cycle by cycle. The optional hazards are a buffer write at
  // guard_at, a start pulse at pulse_at, and a write presented together with start.
  task automatic run1(input int guard_at, input int pulse_at, input bit wr_with_start,
                      input bit use_const, input logic [31:0] cval);
    logic [31:0] exp_c [NN1];
    int p, q;
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin
      a_wr_en = 1'b1; a_wr_row = '0; a_wr_col = 4'd3; a_wr_data = $urandom;
      ref_a[0][3] = a_wr_data;
    end
    for (int e = 0; e < NN1; e++) exp_c[e] = use_const ? cval : dot(row_of(e / N1), col_of(e % N1));
    for (int c = 1; c <= TOT1 + 3; c++) begin
      @(negedge clk);
      start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
      if (c == guard_at) begin
        a_wr_en = 1'b1; a_wr_row = '0; a_wr_col = '0; a_wr_data = 32'h40A0_0000;
        b_wr_en = 1'b1; b_wr_row = '0; b_wr_col = '0; b_wr_data = 32'h40A0_0000;
      end
      if (c == pulse_at) start = 1'b1;
      check($sformatf("busy@%0d", c), 512'(busy), 512'(c <= TOT1));
      check($sformatf("done@%0d", c), 512'(done), 512'(c == TOT1));
      q = (c - 1 < NN1 - 1) ? c - 1 : NN1 - 1;
      check($sformatf("vec_a@%0d", c), vec_a, row_of(q / N1));
      check($sformatf("vec_b@%0d", c), vec_b, col_of(q % N1));
      p = c - 2 - L1;
      check($sformatf("c_valid@%0d", c), 512'(c_valid), 512'(p >= 0 && p < NN1));
      if (p >= 0 && p < NN1) begin
        check($sformatf("c_row@%0d", c), 512'(c_row), 512'(p / N1));
        check($sformatf("c_col@%0d", c), 512'(c_col), 512'(p % N1));
        check($sformatf("c_data@%0d", c), 512'(c_data), 512'(exp_c[p]));
      end
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 512'(busy), '0);
    check({tag, "_done"}, 512'(done), '0);
    check({tag, "_c_valid"}, 512'(c_valid), '0);
    check({tag, "_c_row"}, 512'(c_row), '0);
    check({tag, "_c_col"}, 512'(c_col), '0);
    check({tag, "_c_data"}, 512'(c_data), '0);
    check({tag, "_vec_a"}, vec_a, '0);
    check({tag, "_vec_b"}, vec_b, '0);
  endtask

  typedef struct {
    logic [31:0] a_fill;
    logic [31:0] b_fill;
    logic [31:0] c_exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    // Expected C = 16 * a * b modulo 2^32 for constant-filled matrices.
    tbl[0] = '{32'd1, 32'd2, 32'd32};
    tbl[1] = '{32'd3, 32'd5, 32'd240};
    tbl[2] = '{32'h0001_0000, 32'h0000_0010, 32'h0100_0000};
    tbl[3] = '{32'h1000_0000, 32'd1, 32'h0000_0000};
    tbl[4] = '{FP32_ONE, 32'd2, 32'hF000_0000};

    start = 0; a_wr_en = 0; b_wr_en = 0; a_wr_row = '0; a_wr_col = '0; a_wr_data = '0;
    b_wr_row = '0; b_wr_col = '0; b_wr_data = '0;
    start2 = 0; a2_en = 0; b2_en = 0; a2_row = '0; a2_col = '0; a2_data = '0;
    b2_row = '0; b2_col = '0; b2_data = '0;
    for (int i = 0; i < N1; i++) for (int k = 0; k < 16; k++) begin
      ref_a[i][k] = '0; ref_b[k][i] = '0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Table-driven constant fills.
    foreach (tbl[t]) begin
      for (int i = 0; i < N1; i++) for (int k = 0; k < 16; k++) begin
        ref_a[i][k] = tbl[t].a_fill; ref_b[k][i] = tbl[t].b_fill;
      end
      load_ref();
      run1(0, 0, 1'b0, 1'b1, tbl[t].c_exp);
    end

    // Random matrices against the reference dot products.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N1; i++) for (int k = 0; k < 16; k++) begin
        ref_a[i][k] = $urandom; ref_b[k][i] = $urandom;
      end
      load_ref();
      run1(0, 0, 1'b0, 1'b0, '0);
      run1(0, 0, 1'b1, 1'b0, '0);
    end

    // A write during ISSUE and a start pulse during DRAIN must both be ignored.
    run1(3, 18, 1'b0, 1'b0, '0);
    run1(0, 0, 1'b0, 1'b0, '0);
    @(negedge clk);
    a_wr_en = 1'b1; a_wr_row = '0; a_wr_col = '0; a_wr_data = 32'h40A0_0000;
    ref_a[0][0] = 32'h40A0_0000;
    @(negedge clk);
    a_wr_en = 1'b0;
    run1(0, 0, 1'b0, 1'b0, '0);

    // Start held for 30 cycles gives exactly two back-to-back runs.
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      start = (c < 30);
      check($sformatf("held_busy@%0d", c), 512'(busy), 512'(c >= 1 && c <= 44));
      check($sformatf("held_done@%0d", c), 512'(done), 512'(c == 22 || c == 44));
      check($sformatf("held_cv@%0d", c), 512'(c_valid),
            512'((c >= 7 && c <= 22) || (c >= 29 && c <= 44)));
    end
    start = 1'b0;

    // Asynchronous reset in cycle 10 of a run.
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check($sformatf("postrst_cv@%0d", c), 512'(c_valid), '0);
      check($sformatf("postrst_busy@%0d", c), 512'(busy), '0);
    end
    for (int i = 0; i < N1; i++) for (int k = 0; k < 16; k++) begin
      ref_a[i][k] = '0; ref_b[k][i] = '0;
    end
    run1(0, 0, 1'b0, 1'b0, '0);

    // Small configuration: N=2, LATENCY=1, A all 2, B all 3, so every C is 96.
    for (int i = 0; i < N2; i++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        a2_en = 1'b1; a2_row = IW2'(i); a2_col = 4'(k); a2_data = 32'd2;
        b2_en = 1'b1; b2_row = 4'(k); b2_col = IW2'(i); b2_data = 32'd3;
      end
    end
    @(negedge clk);
    a2_en = 1'b0; b2_en = 1'b0; start2 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      check($sformatf("n2_busy@%0d", c), 512'(busy2), 512'(c >= 1 && c <= 6));
      check($sformatf("n2_done@%0d", c), 512'(done2), 512'(c == 6));
      check($sformatf("n2_cv@%0d", c), 512'(cv2), 512'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check($sformatf("n2_row@%0d", c), 512'(cr2), 512'((c - 3) / 2));
        check($sformatf("n2_col@%0d", c), 512'(cc2), 512'((c - 3) % 2));
        check($sformatf("n2_data@%0d", c), 512'(cd2), 512'(32'd96));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp32_matmul_sequencer.md
# fp32_matmul_sequencer

Operand sequencer and result collector placed directly upstream of `FP32Vector16Multiplier`, the pipelined 16-element FP32 dot-product unit.
- Holds one [N,16] matrix A and one [16,N] matrix B in local register buffers.
- On `start`, issues every (row i of A, column j of B) vector pair to the multiplier back-to-back, one pair per clock, in row-major order.
- Tags each pair with (i,j), matches each returning dot product to its tag after the multiplier latency, and emits C[i][j] as an indexed result stream.

## Interface
Parameters:
- `N`, 4: matrix dimension (rows of A, columns of B); power of two, 2..16.
- `LATENCY`, 5: multiplier latency in cycles, from operands presented to result valid; ≥1.
- `IW`: derived, $clog2(N).

Ports (packed vectors carry element k at bits [32k+31:32k]):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_wr_en` in 1: write strobe, A buffer.
- `a_wr_row` in IW: A row index i.
- `a_wr_col` in 4: A column index k.
- `a_wr_data` in 32: FP32 element A[i][k].
- `b_wr_en` in 1: write strobe, B buffer.
- `b_wr_row` in 4: B row index k.
- `b_wr_col` in IW: B column index j.
- `b_wr_data` in 32: FP32 element B[k][j].
- `start` in 1: launch multiplication.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `vec_a` out 512: row i of A, to the multiplier `vectorA`.
- `vec_b` out 512: column j of B, to the multiplier `vectorB`.
- `mul_result` in 32: multiplier `result`.
- `c_valid` out 1: result strobe.
- `c_row` out IW: i of the current result.
- `c_col` out IW: j of the current result.
- `c_data` out 32: C[i][j], FP32 bit pattern.

## Operation
- States:
  - IDLE: buffers writable.
  - ISSUE: N·N cycles, one pair per cycle.
  - DRAIN: waits for in-flight results.
  - IDLE is re-entered in the cycle `done` pulses.
- IDLE→ISSUE: `start`=1 at a clock edge. ISSUE→DRAIN: after pair (N-1,N-1) is issued. DRAIN→IDLE: at the edge that raises `done`.
- Issue order: i outer, j inner, both wrap 0..N-1. Pair index p = i·N + j.
- Tag pipeline, LATENCY+1 stages deep, carries {valid, i, j}. It advances every cycle whatever the state.
- `c_data` is `mul_result` registered with no arithmetic change; this block does no FP math.
- Buffer writes are accepted only in IDLE; writes in ISSUE/DRAIN are dropped. A write and `start` in the same IDLE cycle: the write lands first and the launch uses the new value.
- `start` during ISSUE/DRAIN is ignored, not queued.
- `vec_a`/`vec_b` hold the last issued pair after ISSUE ends.
- Reset, including mid-operation:
  - state → IDLE; all tag stages invalid; both buffers cleared to 0;
  - `busy`, `done`, `c_valid`, `c_row`, `c_col`, `c_data`, `vec_a`, `vec_b` all 0;
  - in-flight results are discarded and are never emitted after reset.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled at the closing edge E0.
- Pair p is presented on `vec_a`/`vec_b` during cycle 1+p; outputs are registered and updated at E0+p.
- `mul_result` for pair p is sampled at the end of cycle 1+p+LATENCY.
- `c_valid`/`c_row`/`c_col`/`c_data` for pair p are asserted during cycle 2+p+LATENCY, for exactly one cycle each, consecutively with no gaps.
- `busy`: high from cycle 1 through cycle N·N+LATENCY+1 inclusive.
- `done`: high only in cycle N·N+LATENCY+1, coincident with the last `c_valid`. For N=4, LATENCY=5 that is cycle 22.
- Earliest next `start` is sampled at the end of the `done` cycle, giving back-to-back operations.

## Structure
- Package `fp32_matmul_pkg`: `FP32_W`=32, `VEC_LEN`=16, state enum {IDLE, ISSUE, DRAIN}, FP32 constants `FP32_ZERO`, `FP32_ONE`.
- Sub-module `fp32_tag_pipe`: parameterised valid/index delay line (depth, tag width) with async reset of all stages.
- Sequencer, buffers and output registers live in the top module.

## Test plan
- Integration: A all 1.0 (3F800000), B all 2.0 (40000000), real multiplier, N=4, LATENCY=5 → 16 `c_valid` in cycles 7..22, all `c_data`=42000000 (32.0), `done` in cycle 22.
- Ordering: behavioural multiplier model returning {i,j} encoded in the result bits → (c_row,c_col) runs (0,0),(0,1)…(3,3) with no gaps; every `c_data` matches its own tag.
- Write guard: rewrite A[0][0] to 5.0 during ISSUE → write ignored; a second run gives identical C; after `done`, the write in IDLE takes effect.
- Start hazards: `start` held high for 30 cycles → exactly two runs, second `busy` starting cycle 23; `start` pulsed mid-DRAIN → ignored.
- Reset mid-operation: `rst` asserted asynchronously in cycle 10 → all outputs 0 immediately; no `c_valid` until a new `start`; buffers read back 0 (all results 0).
- Parameter sweep: N=2, LATENCY=1 → first `c_valid` in cycle 3, `done` in cycle 6.
